// File: rtl/quad_step_decoder.sv
// quad_step_decoder: raw quadrature A/B pins -> one-cycle step strobe plus direction bit.
// Build option: define QUAD_ERR_CNT_EN to implement the saturating illegal-transition counter.
module quad_step_decoder #(
   parameter int FILTER_CYCLES = 4,
   parameter int ERR_W         = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enc_a,
   input  logic             enc_b,
   input  logic             enable,
   output logic             step,
   output logic             dir,
   output logic             err,
   output logic [ERR_W-1:0] err_count,
   output logic             primed
);
   // state    | meaning
   // UNPRIMED | waiting for both synced channels to sit still, then loads the encoder state
   // TRACK    | filtered {A,B} followed every cycle; steps and errors decoded
   typedef enum logic {UNPRIMED = 1'b0, TRACK = 1'b1} state_t;

   localparam int            CW       = 8;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FILTER_CYCLES);

   state_t        state_q;
   logic [1:0]    meta_q;
   logic [1:0]    sync_q;
   logic [1:0]    filt_q;
   logic [1:0]    cur_q;
   logic [1:0]    prev_q;
   logic [CW-1:0] cnt_q [2];
   logic          warm_q;

   logic [1:0]    chg;
   logic [1:0]    pos_cur;
   logic [1:0]    pos_prev;
   logic          single;
   logic          fwd;
   logic          rev;
   logic          illegal;

   // Bit 1 is channel A, bit 0 is channel B.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= {enc_a, enc_b};
         sync_q <= meta_q;
      end
   end

   // Gray position 00,01,11,10 -> 0,1,2,3; a forward step advances it by one.
   always_comb begin
      chg      = cur_q ^ prev_q;
      pos_cur  = {cur_q[1], cur_q[1] ^ cur_q[0]};
      pos_prev = {prev_q[1], prev_q[1] ^ prev_q[0]};
      single   = (chg == 2'b01) || (chg == 2'b10);
      illegal  = (chg == 2'b11);
      fwd      = single && (pos_cur == pos_prev + 2'd1);
      rev      = single && (pos_prev == pos_cur + 2'd1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= UNPRIMED;
         filt_q   <= '0;
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
         warm_q   <= 1'b0;
         cur_q    <= '0;
         prev_q   <= '0;
         step     <= 1'b0;
         dir      <= 1'b0;
         err      <= 1'b0;
         primed   <= 1'b0;
      end else begin
         step <= 1'b0;
         err  <= 1'b0;
         case (state_q)
            UNPRIMED: begin
               // filt_q shadows sync_q here so the counters measure how long each channel has been still.
               warm_q <= 1'b1;
               filt_q <= sync_q;
               for (int i = 0; i < 2; i++) begin
                  if (!warm_q || (sync_q[i] != filt_q[i])) begin
                     cnt_q[i] <= '0;
                  end else if (cnt_q[i] != CNT_FULL) begin
                     cnt_q[i] <= cnt_q[i] + 1'b1;
                  end
               end
               if ((cnt_q[0] == CNT_FULL) && (cnt_q[1] == CNT_FULL)) begin
                  state_q  <= TRACK;
                  primed   <= 1'b1;
                  cnt_q[0] <= '0;
                  cnt_q[1] <= '0;
                  cur_q    <= sync_q;
                  prev_q   <= sync_q;
               end
            end
            TRACK: begin
               for (int i = 0; i < 2; i++) begin
                  if (sync_q[i] == filt_q[i]) begin
                     cnt_q[i] <= '0;
                  end else if (cnt_q[i] == CNT_LAST) begin
                     filt_q[i] <= sync_q[i];
                     cnt_q[i]  <= '0;
                  end else begin
                     cnt_q[i] <= cnt_q[i] + 1'b1;
                  end
               end
               cur_q  <= filt_q;
               prev_q <= cur_q;
               if (enable) begin
                  step <= fwd || rev;
                  err  <= illegal;
                  if (fwd || rev) begin
                     dir <= rev;
                  end
               end
            end
            default: state_q <= UNPRIMED;
         endcase
      end
   end

`ifdef QUAD_ERR_CNT_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_count <= '0;
      end else if ((state_q == TRACK) && enable && illegal && (err_count != {ERR_W{1'b1}})) begin
         err_count <= err_count + 1'b1;
      end
   end
`else
   assign err_count = '0;
`endif

endmodule
